// File: rtl/operand2_decode_stage.sv
// Operand2 decode stage: turns an ARM data-processing operand2 field into barrel-shifter
// operands (data, op, 5-bit amount) plus the shifter carry-out, registered for EX.
module operand2_decode_stage #(
    parameter int DATA_W  = 32,
    parameter int RS_BYTE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rm_data,
    input  logic              in_carry,
    output logic              rs_rd_en,
    output logic [3:0]        rs_rd_addr,
    input  logic [DATA_W-1:0] rs_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] shift_in,
    output logic [1:0]        shift_op,
    output logic [4:0]        shift_amt,
    output logic              out_carry
);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {IDLE, RS_WAIT, FULL} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        op;
        logic [4:0]        amt;
        logic              carry;
    } shift_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              is_reg_in;
    logic              load_in;
    logic              load_rs;
    logic [1:0]        typ_p0;
    logic [DATA_W-1:0] rm_p0;
    logic              carry_p0;
    shift_t            dec_in;
    shift_t            dec_rs;
    logic              unused_bits;

    // Rotated immediate and immediate-specified shifts; #0 encodings map to #32 / RRX.
    function automatic shift_t decode_imm(input logic [31:0] instr,
                                          input logic [DATA_W-1:0] rm,
                                          input logic cin);
        shift_t      r;
        logic [4:0]  n;
        logic [31:0] imm;
        logic [63:0] dbl;
        n       = instr[11:7];
        imm     = {24'b0, instr[7:0]};
        r.data  = rm;
        r.op    = instr[6:5];
        r.amt   = n;
        r.carry = cin;
        if (instr[25]) begin
            r.data  = imm;
            r.op    = OP_ROR;
            r.amt   = {instr[11:8], 1'b0};
            dbl     = {imm, imm} >> r.amt;
            r.carry = (instr[11:8] == 4'd0) ? cin : dbl[31];
        end else begin
            case (instr[6:5])
                OP_LSL: r.carry = (n == 5'd0) ? cin : rm[5'd0 - n];
                OP_LSR: begin
                    if (n == 5'd0) begin
                        r.data  = '0;
                        r.carry = rm[31];
                    end else begin
                        r.carry = rm[n - 5'd1];
                    end
                end
                OP_ASR: begin
                    if (n == 5'd0) begin
                        r.amt   = 5'd31;
                        r.carry = rm[31];
                    end else begin
                        r.carry = rm[n - 5'd1];
                    end
                end
                default: begin
                    if (n == 5'd0) begin
                        r.data  = {cin, rm[31:1]};
                        r.op    = OP_LSL;
                        r.amt   = 5'd0;
                        r.carry = rm[0];
                    end else begin
                        r.carry = rm[n - 5'd1];
                    end
                end
            endcase
        end
        return r;
    endfunction

    // Register-specified shifts: amounts of 32 and above saturate to what the shifter can express.
    function automatic shift_t decode_reg(input logic [1:0] typ,
                                          input logic [DATA_W-1:0] rm,
                                          input logic cin,
                                          input logic [RS_BYTE-1:0] n);
        shift_t     r;
        logic [4:0] k;
        logic       eq32;
        logic       big;
        k       = n[4:0];
        eq32    = (n == RS_BYTE'(32));
        big     = (n > RS_BYTE'(32));
        r.data  = rm;
        r.op    = typ;
        r.amt   = k;
        r.carry = cin;
        if (n == '0) begin
            r.op  = OP_LSL;
            r.amt = 5'd0;
        end else begin
            case (typ)
                OP_LSL, OP_LSR: begin
                    if (eq32 || big) begin
                        r.data  = '0;
                        r.amt   = 5'd0;
                        r.carry = big ? 1'b0 : ((typ == OP_LSL) ? rm[0] : rm[31]);
                    end else begin
                        r.carry = (typ == OP_LSL) ? rm[5'd0 - k] : rm[k - 5'd1];
                    end
                end
                OP_ASR: begin
                    if (eq32 || big) begin
                        r.amt   = 5'd31;
                        r.carry = rm[31];
                    end else begin
                        r.carry = rm[k - 5'd1];
                    end
                end
                default: r.carry = (k == 5'd0) ? rm[31] : rm[k - 5'd1];
            endcase
        end
        return r;
    endfunction

    assign is_reg_in   = !in_instr[25] && in_instr[4];
    assign accept      = in_valid && in_ready;
    assign load_in     = accept && !is_reg_in;
    assign load_rs     = (state == RS_WAIT) && !flush;
    assign rs_rd_addr  = in_instr[11:8];
    assign out_valid   = (state == FULL);
    assign dec_in      = decode_imm(in_instr, in_rm_data, in_carry);
    assign dec_rs      = decode_reg(typ_p0, rm_p0, carry_p0, rs_rd_data[RS_BYTE-1:0]);
    assign unused_bits = ^{in_instr[31:26], in_instr[24:12], rs_rd_data[DATA_W-1:RS_BYTE]};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rs_rd_en  = 1'b0;
        in_ready  = !flush && ((state == IDLE) || ((state == FULL) && out_ready));
        rs_rd_en  = rst_n && in_valid && in_ready && is_reg_in;
        case (state)
            IDLE:    if (accept) state_nxt = is_reg_in ? RS_WAIT : FULL;
            RS_WAIT: state_nxt = FULL;
            FULL: begin
                if (out_ready) begin
                    if (accept) state_nxt = is_reg_in ? RS_WAIT : FULL;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // p0: operands held while the shared register-file port returns Rs
    always_ff @(posedge clk) begin
        if (accept && is_reg_in) begin
            typ_p0   <= in_instr[6:5];
            rm_p0    <= in_rm_data;
            carry_p0 <= in_carry;
        end
    end

    // Output stage: the registers feeding the barrel shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_in  <= '0;
            shift_op  <= 2'b00;
            shift_amt <= 5'd0;
            out_carry <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_in) begin
                {shift_in, shift_op, shift_amt, out_carry} <= dec_in;
            end else if (load_rs) begin
                {shift_in, shift_op, shift_amt, out_carry} <= dec_rs;
            end
        end
    end

endmodule

// File: tb/tb_operand2_decode_stage.sv
// Scoreboard bench for operand2_decode_stage: directed operand2 vectors with hand-computed
// shifter operands, plus latency, back-pressure, flush and async-reset checks.
module tb_operand2_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rm_data;
    logic        in_carry;
    logic        rs_rd_en;
    logic [3:0]  rs_rd_addr;
    logic [31:0] rs_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] shift_in;
    logic [1:0]  shift_op;
    logic [4:0]  shift_amt;
    logic        out_carry;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  op;
        logic [4:0]  amt;
        logic        c;
    } exp_t;

    typedef struct {
        string name;
        exp_t  v;
    } sb_t;

    sb_t q[$];

    operand2_decode_stage #(.DATA_W(32), .RS_BYTE(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rm_data(in_rm_data), .in_carry(in_carry),
        .rs_rd_en(rs_rd_en), .rs_rd_addr(rs_rd_addr), .rs_rd_data(rs_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .shift_in(shift_in), .shift_op(shift_op), .shift_amt(shift_amt), .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] d, input logic [1:0] op,
                                input logic [4:0] amt, input logic c);
        exp_t e;
        e.d = d; e.op = op; e.amt = amt; e.c = c;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every handshake on the output side is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h expected none",
                         {shift_in, shift_op, shift_amt, out_carry});
            end else begin
                sb_t s;
                s = q.pop_front();
                chk({s.name, "_out"}, {24'b0, shift_in, shift_op, shift_amt, out_carry}, {24'b0, s.v});
            end
        end
    end

    // Issue one instruction from IDLE with out_ready=1; checks Rs port use and latency.
    task automatic issue(input string name, input logic [31:0] instr, input logic [31:0] rm,
                         input logic cin, input logic [31:0] rs, input exp_t e);
        logic is_reg;
        int   waitc;
        is_reg     = !instr[25] && instr[4];
        in_instr   = instr;
        in_rm_data = rm;
        in_carry   = cin;
        in_valid   = 1'b1;
        @(negedge clk);
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            chk({name, "_accept_timeout"}, in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        chk({name, "_rs_en"}, rs_rd_en, is_reg);
        if (is_reg) chk({name, "_rs_addr"}, rs_rd_addr, instr[11:8]);
        q.push_back('{name, e});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (is_reg) begin
            rs_rd_data = rs;
            @(negedge clk);
            chk({name, "_wait_vld"}, out_valid, 0);
            chk({name, "_rs_en_idle"}, rs_rd_en, 0);
            @(posedge clk);
            #1;
            rs_rd_data = 32'hDEADBEEF;
        end
        @(negedge clk);
        chk({name, "_vld"}, out_valid, 1);
        @(posedge clk);
        #1;
    endtask

    exp_t  b2b_e[4];
    logic [31:0] b2b_i[4];
    logic        b2b_c[4];

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_rm_data = '0;
        in_carry   = 1'b0;
        rs_rd_data = 32'hDEADBEEF;
        out_ready  = 1'b1;
        #2;
        chk("reset_vld", out_valid, 0);
        chk("reset_outs", {shift_in, shift_op, shift_amt, out_carry}, 0);
        chk("reset_rs_en", rs_rd_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // rotated immediates and immediate-specified shifts
        issue("imm_rot4",  32'h03A004FF, 32'h0,        1'b0, 0, mk(32'hFF,        2'b11, 5'd8,  1'b1));
        issue("imm_rot0",  32'h03A000FF, 32'h0,        1'b1, 0, mk(32'hFF,        2'b11, 5'd0,  1'b1));
        issue("lsr0",      32'h01A00020, 32'h80000001, 1'b0, 0, mk(32'h0,         2'b01, 5'd0,  1'b1));
        issue("asr0",      32'h01A00040, 32'h80000000, 1'b0, 0, mk(32'h80000000,  2'b10, 5'd31, 1'b1));
        issue("rrx",       32'h01A00060, 32'h00000003, 1'b1, 0, mk(32'h80000001,  2'b00, 5'd0,  1'b1));
        issue("lsl4",      32'h01A00200, 32'hF0000000, 1'b0, 0, mk(32'hF0000000,  2'b00, 5'd4,  1'b1));
        issue("lsr1",      32'h01A000A0, 32'h00000002, 1'b1, 0, mk(32'h2,         2'b01, 5'd1,  1'b0));
        issue("lsl0",      32'h01A00000, 32'h00001234, 1'b1, 0, mk(32'h1234,      2'b00, 5'd0,  1'b1));
        issue("ror8",      32'h01A00460, 32'h00000080, 1'b0, 0, mk(32'h80,        2'b11, 5'd8,  1'b1));

        // register-specified shifts
        issue("rlsl33",    32'h01A00210, 32'h12345678, 1'b1, 32'h21,  mk(32'h0,        2'b00, 5'd0,  1'b0));
        issue("rlsl32",    32'h01A00210, 32'h00000001, 1'b0, 32'h20,  mk(32'h0,        2'b00, 5'd0,  1'b1));
        issue("rlsr32",    32'h01A00330, 32'h80000000, 1'b0, 32'h20,  mk(32'h0,        2'b01, 5'd0,  1'b1));
        issue("rasr64",    32'h01A00450, 32'h80000000, 1'b0, 32'h40,  mk(32'h80000000, 2'b10, 5'd31, 1'b1));
        issue("rror36",    32'h01A00570, 32'h0000000F, 1'b0, 32'h24,  mk(32'hF,        2'b11, 5'd4,  1'b1));
        issue("rror32",    32'h01A00670, 32'h80000000, 1'b0, 32'h20,  mk(32'h80000000, 2'b11, 5'd0,  1'b1));
        issue("rzero",     32'h01A00750, 32'h0000ABCD, 1'b1, 32'h100, mk(32'hABCD,     2'b00, 5'd0,  1'b1));
        issue("rlsl4",     32'h01A00810, 32'h10000000, 1'b0, 32'h4,   mk(32'h10000000, 2'b00, 5'd4,  1'b1));

        // back-to-back immediates with out_ready held high
        b2b_i[0] = 32'h03A004FF; b2b_c[0] = 1'b0; b2b_e[0] = mk(32'hFF, 2'b11, 5'd8,  1'b1);
        b2b_i[1] = 32'h03A000FF; b2b_c[1] = 1'b1; b2b_e[1] = mk(32'hFF, 2'b11, 5'd0,  1'b1);
        b2b_i[2] = 32'h03A00F01; b2b_c[2] = 1'b0; b2b_e[2] = mk(32'h01, 2'b11, 5'd30, 1'b0);
        b2b_i[3] = 32'h03A00102; b2b_c[3] = 1'b0; b2b_e[3] = mk(32'h02, 2'b11, 5'd2,  1'b1);
        for (int i = 0; i < 4; i++) begin
            in_instr = b2b_i[i];
            in_carry = b2b_c[i];
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("b2b%0d_ready", i), in_ready, 1);
            if (i > 0) chk($sformatf("b2b%0d_vld", i), out_valid, 1);
            if (in_ready) q.push_back('{$sformatf("b2b%0d", i), b2b_e[i]});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_vld", out_valid, 1);
        @(posedge clk);
        #1;

        // back-pressure: output held for 3 cycles while the next instruction waits
        out_ready = 1'b0;
        in_instr  = 32'h03A004FF;
        in_carry  = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        q.push_back('{"hold_a", mk(32'hFF, 2'b11, 5'd8, 1'b1)});
        @(posedge clk);
        #1;
        in_instr   = 32'h01A00040;
        in_rm_data = 32'h80000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_vld", i), out_valid, 1);
            chk($sformatf("hold%0d_ready", i), in_ready, 0);
            chk($sformatf("hold%0d_data", i), {shift_in, shift_op, shift_amt, out_carry},
                {32'hFF, 2'b11, 5'd8, 1'b1});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_ready", in_ready, 1);
        q.push_back('{"hold_b", mk(32'h80000000, 2'b10, 5'd31, 1'b1)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;

        // flush while waiting on Rs discards the instruction
        in_instr   = 32'h01A00210;
        in_rm_data = 32'h00000001;
        in_valid   = 1'b1;
        @(negedge clk);
        chk("flush_rs_en", rs_rd_en, 1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        flush      = 1'b1;
        rs_rd_data = 32'h20;
        @(negedge clk);
        chk("flush_wait_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        rs_rd_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("flush_vld", out_valid, 0);
        chk("flush_idle_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // flush dominates in_valid in IDLE
        in_instr = 32'h01A00210;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_dom_ready", in_ready, 0);
        chk("flush_dom_rs_en", rs_rd_en, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_dom_vld", out_valid, 0);
        @(posedge clk);
        #1;

        // asynchronous reset while FULL
        out_ready = 1'b0;
        in_instr  = 32'h03A004FF;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_full_vld_before", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_vld", out_valid, 0);
        chk("rst_async_outs", {shift_in, shift_op, shift_amt, out_carry}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        issue("post_rst", 32'h01A00060, 32'h00000002, 1'b0, 0, mk(32'h00000001, 2'b00, 5'd0, 1'b0));

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
